irrigation_circuit: RTL and testbench



---
 rtl/irrigation_pkg.sv | 36 +++
 rtl/crop_threshold_lut.sv | 31 +++
 rtl/irrigation_circuit.sv | 134 +++++++++++++
 tb/tb_irrigation_circuit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared types and constants for the HYDRO-SURE irrigation decision block.
//   crop_e       : valid crop codes (5..15 are invalid)
//   crop_thr_t   : moisture low/high band and maximum temperature per crop
//   DEF_THR      : thresholds used for invalid crop codes
//   pump_state_e : pump FSM states (hysteresis build only)
package irrigation_pkg;

    localparam int unsigned SENSE_W    = 4;
    localparam int unsigned HOT_T      = 8;
    localparam int unsigned MIN_ON_CYC = 4;

    typedef enum logic [SENSE_W-1:0] {
        RICE      = 4'd0,
        WHEAT     = 4'd1,
        MAIZE     = 4'd2,
        COTTON    = 4'd3,
        SUGARCANE = 4'd4
    } crop_e;

    typedef struct packed {
        logic [SENSE_W-1:0] lo;
        logic [SENSE_W-1:0] hi;
        logic [SENSE_W-1:0] tmax;
    } crop_thr_t;

    localparam logic [SENSE_W-1:0] DEF_LO   = 4'd8;
    localparam logic [SENSE_W-1:0] DEF_HI   = 4'd12;
    localparam logic [SENSE_W-1:0] DEF_TMAX = 4'd11;
    localparam crop_thr_t          DEF_THR  = '{lo: DEF_LO, hi: DEF_HI, tmax: DEF_TMAX};

    typedef enum logic {
        IDLE = 1'b0,
        PUMP = 1'b1
    } pump_state_e;

endpackage

// File: rtl/crop_threshold_lut.sv
// Combinational crop-code to threshold lookup.
//   ct         in  4  crop type code
//   thr_c      out    {lo, hi, tmax} thresholds for the crop
//   bad_crop_c out 1  crop code not in the table (defaults applied)
module crop_threshold_lut
    import irrigation_pkg::*;
(
    input  logic [SENSE_W-1:0] ct,
    output crop_thr_t          thr_c,
    output logic               bad_crop_c
);

    crop_e crop;

    assign crop = crop_e'(ct);

    // Table lookup; anything outside the enum falls back to the defaults
    always_comb begin
        thr_c      = DEF_THR;
        bad_crop_c = 1'b0;
        case (crop)
            RICE:      thr_c = '{lo: 4'd10, hi: 4'd14, tmax: 4'd12};
            WHEAT:     thr_c = '{lo: 4'd6,  hi: 4'd10, tmax: 4'd10};
            MAIZE:     thr_c = '{lo: 4'd7,  hi: 4'd11, tmax: 4'd11};
            COTTON:    thr_c = '{lo: 4'd5,  hi: 4'd9,  tmax: 4'd13};
            SUGARCANE: thr_c = '{lo: 4'd9,  hi: 4'd13, tmax: 4'd12};
            default:   bad_crop_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/irrigation_circuit.sv
// Smart-irrigation decision block: registered pump enable, moisture-OK and alert.
//   clk in  1  clock, rising edge
//   rst in  1  synchronous active-high reset
//   ms  in  4  moisture reading (0 dry .. 15 saturated)
//   ts  in  4  temperature reading
//   ct  in  4  crop type code
//   o1  out 1  pump enable
//   o2  out 1  moisture within crop band
//   o3  out 1  alert
// Build option: define IRR_HYSTERESIS_EN for the pump FSM with minimum on-time;
// otherwise the pump flag follows the low-moisture condition directly.
module irrigation_circuit
    import irrigation_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SENSE_W-1:0] ms,
    input  logic [SENSE_W-1:0] ts,
    input  logic [SENSE_W-1:0] ct,
    output logic               o1,
    output logic               o2,
    output logic               o3
);

    crop_thr_t          thr_c;
    logic               bad_crop_c;
    logic [SENSE_W-1:0] ct_q;
    logic               crop_changed_c;
    logic               hot_c;
    logic [SENSE_W:0]   eff_lo_c;
    logic               below_lo_c;
    logic               sat_c;
    logic               o2_d;
    logic               o3_d;

    crop_threshold_lut u_lut (
        .ct         (ct),
        .thr_c      (thr_c),
        .bad_crop_c (bad_crop_c)
    );

    // Hot weather raises the low threshold by one; 5 bits keeps the sum exact
    assign hot_c          = (ts >= SENSE_W'(HOT_T));
    assign eff_lo_c       = {1'b0, thr_c.lo} + {{SENSE_W{1'b0}}, hot_c};
    assign below_lo_c     = ({1'b0, ms} < eff_lo_c);
    assign sat_c          = (ms == {SENSE_W{1'b1}});
    assign crop_changed_c = (ct != ct_q);

    assign o2_d = !below_lo_c && (ms <= thr_c.hi);
    assign o3_d = (ts > thr_c.tmax) || sat_c || bad_crop_c;

    // Flag registers and crop history
    always_ff @(posedge clk) begin
        if (rst) begin
            ct_q <= '0;
            o2   <= 1'b0;
            o3   <= 1'b0;
        end else begin
            ct_q <= ct;
            o2   <= o2_d;
            o3   <= o3_d;
        end
    end

`ifdef IRR_HYSTERESIS_EN
    localparam int unsigned TMR_W = (MIN_ON_CYC > 2) ? $clog2(MIN_ON_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MIN_ON_CYC - 1);

    pump_state_e      state_q;
    pump_state_e      state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             at_hi_c;

    assign at_hi_c = (ms >= thr_c.hi);

    // State and on-timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Next state: crop change and saturation override the minimum on-time
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (crop_changed_c) begin
            state_d = IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (below_lo_c) begin
                        state_d = PUMP;
                        tmr_d   = TMR_LOAD;
                    end
                end
                PUMP: begin
                    if (sat_c || (at_hi_c && (tmr_q == '0))) begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q != '0) begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // Pump enable decodes straight from the state flop
    always_comb begin
        o1 = (state_q == PUMP);
    end
`else
    // Pump enable without hysteresis
    always_ff @(posedge clk) begin
        if (rst) begin
            o1 <= 1'b0;
        end else begin
            o1 <= below_lo_c && !sat_c && !crop_changed_c;
        end
    end
`endif

endmodule

// File: tb/tb_irrigation_circuit.sv
// Directed-vector bench for irrigation_circuit; expectations adapt to IRR_HYSTERESIS_EN.
module tb_irrigation_circuit;

`ifdef IRR_HYSTERESIS_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] ms;
    logic [3:0] ts;
    logic [3:0] ct;
    logic       o1;
    logic       o2;
    logic       o3;

    int n_vec = 0;
    int n_err = 0;

    irrigation_circuit dut (
        .clk (clk),
        .rst (rst),
        .ms  (ms),
        .ts  (ts),
        .ct  (ct),
        .o1  (o1),
        .o2  (o2),
        .o3  (o3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic e1, input logic e2, input logic e3);
        chk({tag, " o1"}, o1, e1);
        chk({tag, " o2"}, o2, e2);
        chk({tag, " o3"}, o3, e3);
    endtask

    // Apply inputs, clock once, sample just after the edge
    task automatic step(input logic [3:0] m, input logic [3:0] t, input logic [3:0] c);
        ms = m;
        ts = t;
        ct = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ms  = 4'd0;
        ts  = 4'd0;
        ct  = 4'd0;
        #1;

        // Reset with arbitrary inputs
        step(4'd15, 4'd15, 4'd9);
        chk_flags("rst0", 1'b0, 1'b0, 1'b0);
        step(4'd2, 4'd14, 4'd0);
        chk_flags("rst1", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Wheat: first cycle is a crop change from ct_q=0
        step(4'd8, 4'd5, 4'd1);
        chk_flags("wheat settle", 1'b0, 1'b1, 1'b0);

        // Moisture sweep, wheat band 6..10, tmax 10
        for (int m = 0; m < 16; m++) begin
            step(4'(m), 4'd5, 4'd1);
            chk_flags($sformatf("sweep ms=%0d", m),
                      HYST ? (m < 10) : (m < 6),
                      (m >= 6) && (m <= 10),
                      (m == 15));
        end

        // Rice, hot threshold shift
        step(4'd10, 4'd7, 4'd0);
        chk_flags("rice chg", 1'b0, 1'b1, 1'b0);
        step(4'd10, 4'd7, 4'd0);
        chk_flags("rice ms=lo", 1'b0, 1'b1, 1'b0);
        step(4'd10, 4'd8, 4'd0);
        chk_flags("rice hot", 1'b1, 1'b0, 1'b0);

        // Crop switch while pumping
        step(4'd4, 4'd8, 4'd0);
        chk_flags("rice pump", 1'b1, 1'b0, 1'b0);
        step(4'd4, 4'd8, 4'd1);
        chk_flags("switch drop", 1'b0, 1'b0, 1'b0);
        step(4'd4, 4'd8, 4'd1);
        chk_flags("switch resume", 1'b1, 1'b0, 1'b0);

        // Maize temperature boundary and invalid crop
        step(4'd9, 4'd11, 4'd2);
        chk_flags("maize ts=tmax", 1'b0, 1'b1, 1'b0);
        step(4'd9, 4'd12, 4'd2);
        chk_flags("maize ts=tmax+1", 1'b0, 1'b1, 1'b1);
        step(4'd9, 4'd3, 4'd7);
        chk_flags("bad crop chg", 1'b0, 1'b1, 1'b1);
        step(4'd2, 4'd3, 4'd7);
        chk_flags("bad crop dry", 1'b1, 1'b0, 1'b1);

        // Cotton minimum on-time
        step(4'd7, 4'd3, 4'd3);
        chk_flags("cotton chg", 1'b0, 1'b1, 1'b0);
        step(4'd3, 4'd3, 4'd3);
        chk_flags("cotton dry", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(4'd9, 4'd3, 4'd3);
            chk_flags($sformatf("cotton hold %0d", i), HYST ? (i < 3) : 1'b0, 1'b1, 1'b0);
        end

        // Saturation ends pumping at once
        step(4'd3, 4'd3, 4'd3);
        chk_flags("sat pre", 1'b1, 1'b0, 1'b0);
        step(4'd15, 4'd3, 4'd3);
        chk_flags("sat", 1'b0, 1'b0, 1'b1);

        // Reset mid-pump
        step(4'd3, 4'd3, 4'd3);
        chk_flags("rst pre", 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step(4'd3, 4'd3, 4'd3);
        chk_flags("rst mid", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(4'd3, 4'd3, 4'd3);
        chk_flags("rst post chg", 1'b0, 1'b0, 1'b0);
        step(4'd3, 4'd3, 4'd3);
        chk_flags("rst post", 1'b1, 1'b0, 1'b0);

        // Wheat tmax boundary with hot offset
        step(4'd8, 4'd11, 4'd1);
        chk_flags("wheat ts=11", 1'b0, 1'b1, 1'b1);
        step(4'd8, 4'd10, 4'd1);
        chk_flags("wheat ts=10", 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
